// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the registered ALU.
//   OP_*    4-bit opcode map
//   SH_*    shift kind, equal to op[1:0] of the shift opcodes (0x8..0xB)
//   F_*     bit positions inside the {S,Z,C,V} flag vector
//   state_e FSM encoding
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_RS7 = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SLR = 4'h9;
    localparam logic [3:0] OP_SRL = 4'hA;
    localparam logic [3:0] OP_SRA = 4'hB;
    localparam logic [3:0] OP_IN  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hD;
    localparam logic [3:0] OP_RSE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SLR = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    localparam int F_S = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/alu_if.sv
// alu_if: request/response handshake bundle of the ALU.
//   Request : in_valid, in_ready, in_a, in_b, op
//   Response: out_valid, out_ready, out, szcv {S,Z,C,V}, out_we
//   master = producer of operands / consumer of results, slave = the ALU.
interface alu_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       szcv;
    logic             out_we;

    modport master (
        output in_valid, in_a, in_b, op, out_ready,
        input  in_ready, out_valid, out, szcv, out_we
    );
    modport slave (
        input  in_valid, in_a, in_b, op, out_ready,
        output in_ready, out_valid, out, szcv, out_we
    );
endinterface

// File: rtl/alu_arith.sv
// alu_arith: combinational single-cycle part of the ALU.
//   a, b  : operands
//   op    : opcode
//   res   : result
//   szcv  : {S,Z,C,V}
//   we    : result is to be written back
// For shift opcodes it returns the zero-distance result (a, C=0), which the
// sequencer uses directly when the shift amount is 0.
module alu_arith
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       szcv,
    output logic             we
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c;
    logic           v;
    logic           flags_en;

    // Bit WIDTH of the extended sum is the carry; of the difference, the borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res      = '0;
        c        = 1'b0;
        v        = 1'b0;
        we       = 1'b0;
        flags_en = 1'b1;
        case (op)
            OP_ADD: begin
                {c, res} = sum;
                v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                we = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                {c, res} = diff;
                v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                we = (op == OP_SUB);
            end
            OP_AND: begin res = a & b; we = 1'b1; end
            OP_OR:  begin res = a | b; we = 1'b1; end
            OP_XOR: begin res = a ^ b; we = 1'b1; end
            OP_MOV, OP_IN: begin res = b; we = 1'b1; end
            OP_OUT: res = a;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin res = a; we = 1'b1; end
            default: flags_en = 1'b0;  // reserved / HLT: all-zero, even Z
        endcase
        szcv = '0;
        if (flags_en) begin
            szcv[F_S] = res[WIDTH-1];
            szcv[F_Z] = (res == '0);
            szcv[F_C] = c;
            szcv[F_V] = v;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and iterative shifter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_if.slave (operands/op in, result/flags/write-enable out)
// Non-shift ops complete at the accept edge; shifts move one bit per cycle
// for in_b[SHAMT_W-1:0] cycles. Result is held in DONE until out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         szcv_q, szcv_d;
    logic               we_q, we_d;

    logic [WIDTH-1:0]   ar_res;
    logic [3:0]         ar_szcv;
    logic               ar_we;
    logic [WIDTH-1:0]   step_val;
    logic               step_c;
    logic               accept;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;

    alu_arith #(.WIDTH(WIDTH)) u_arith (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .op   (bus.op),
        .res  (ar_res),
        .szcv (ar_szcv),
        .we   (ar_we)
    );

    assign accept   = bus.in_valid && (state_q == ST_IDLE);
    assign is_shift = (bus.op[3:2] == 2'b10);
    assign shamt    = bus.in_b[SHAMT_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            kind_q  <= SH_SLL;
            out_q   <= '0;
            szcv_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            out_q   <= out_d;
            szcv_q  <= szcv_d;
            we_q    <= we_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.in_valid)
                          state_d = (is_shift && shamt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // One shift step of the working register
    always_comb begin
        step_val = sh_q;
        step_c   = 1'b0;
        case (kind_q)
            SH_SLL: begin step_val = {sh_q[WIDTH-2:0], 1'b0};         step_c = sh_q[WIDTH-1]; end
            SH_SLR: begin step_val = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; step_c = sh_q[WIDTH-1]; end
            SH_SRL: begin step_val = {1'b0, sh_q[WIDTH-1:1]};         step_c = sh_q[0];       end
            default: begin step_val = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; step_c = sh_q[0];    end
        endcase
    end

    // Datapath: capture at accept; shifts overwrite result on their last step
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        out_d  = out_q;
        szcv_d = szcv_q;
        we_d   = we_q;
        if (accept) begin
            sh_d   = bus.in_a;
            cnt_d  = shamt;
            kind_d = bus.op[1:0];
            out_d  = ar_res;
            szcv_d = ar_szcv;
            we_d   = ar_we;
        end else if (state_q == ST_SHIFT) begin
            sh_d  = step_val;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                out_d       = step_val;
                szcv_d[F_S] = step_val[WIDTH-1];
                szcv_d[F_Z] = (step_val == '0);
                szcv_d[F_C] = step_c;
                szcv_d[F_V] = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.out       = out_q;
        bus.szcv      = szcv_q;
        bus.out_we    = we_q;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven check of alu_seq (WIDTH=16) plus
// hand-written backpressure and mid-shift reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [3:0]  szcv;
        logic        we;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] o, input logic [3:0] f,
                       input logic we, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b;
        v.out = o; v.szcv = f; v.we = we; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int guard;
        int lat;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin tick(); guard++; end
        chk({v.name, " ready-before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = v.op;
        bus.in_a = v.a;
        bus.in_b = v.b;
        tick();
        // operands must have been captured at accept only
        bus.in_valid = 1'b0;
        bus.in_a = ~v.a;
        bus.in_b = ~v.b;
        bus.op = ~v.op;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, " out"}, 32'(bus.out), 32'(v.out));
        chk({v.name, " szcv"}, 32'(bus.szcv), 32'(v.szcv));
        chk({v.name, " out_we"}, 32'(bus.out_we), 32'(v.we));
        chk({v.name, " in_ready in DONE"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({v.name, " idle after pop"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        vec_t v;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.op = OP_ADD;
        bus.out_ready = 1'b0;

        //     name          op      a        b        out      szcv     we  lat
        add("add_ovf",    OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, 1);
        add("cmp_eq",     OP_CMP, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 0, 1);
        add("sub_borrow", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1, 1);
        add("sra3",       OP_SRA, 16'h8001, 16'h0003, 16'hF000, 4'b1000, 1, 4);
        add("sll1",       OP_SLL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1, 2);
        add("slr4",       OP_SLR, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1, 5);
        add("srl0",       OP_SRL, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1, 1);
        add("add_carry",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1, 1);
        add("add_cv",     OP_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b0111, 1, 1);
        add("sub_v",      OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1, 1);
        add("and",        OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1, 1);
        add("or_zero",    OP_OR,  16'h0000, 16'h0000, 16'h0000, 4'b0100, 1, 1);
        add("xor",        OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b1000, 1, 1);
        add("mov",        OP_MOV, 16'h1234, 16'h8000, 16'h8000, 4'b1000, 1, 1);
        add("in",         OP_IN,  16'h0001, 16'h0000, 16'h0000, 4'b0100, 1, 1);
        add("out",        OP_OUT, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0000, 0, 1);
        add("rsv7",       OP_RS7, 16'h0001, 16'h0002, 16'h0000, 4'b0000, 0, 1);
        add("rsvE",       OP_RSE, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 0, 1);
        add("hlt",        OP_HLT, 16'h0001, 16'h0002, 16'h0000, 4'b0000, 0, 1);
        add("srl15",      OP_SRL, 16'h8001, 16'h000F, 16'h0001, 4'b0000, 1, 16);
        add("sra_slice",  OP_SRA, 16'h8000, 16'h0011, 16'hC000, 4'b1000, 1, 2);
        add("slr1",       OP_SLR, 16'h8000, 16'h0001, 16'h0001, 4'b0010, 1, 2);

        // reset state
        tick(); tick();
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out", 32'(bus.out), 32'd0);
        chk("reset szcv", 32'(bus.szcv), 32'd0);
        chk("reset out_we", 32'(bus.out_we), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure: result held for 5 cycles while a new request waits
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.in_a = 16'h0001; bus.in_b = 16'h0002;
        tick();
        bus.op = OP_XOR; bus.in_a = 16'hFFFF; bus.in_b = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp out", 32'(bus.out), 32'h0003);
            chk("bp szcv", 32'(bus.szcv), 32'b0000);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp pop idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        tick();
        chk("bp no stray accept", 32'(bus.out_valid), 32'd0);

        // reset during the 2nd cycle of SRA by 8
        bus.in_valid = 1'b1; bus.op = OP_SRA; bus.in_a = 16'h8001; bus.in_b = 16'h0008;
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out", 32'(bus.out), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst szcv", 32'(bus.szcv), 32'd0);
        tick(); tick();
        chk("rst stays idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        v = vecs[0];
        v.name = "post_rst_add";
        run_vec(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
